// File: rtl/aes_fifo_host_driver.sv
// rtl/aes_fifo_host_driver.sv - host-side driver feeding and draining the AES FIFO pair
// Optional watchdog: define AES_DRV_TIMEOUT_EN to abort stalled runs after TIMEOUT_CYCLES idle cycles.
module aes_fifo_host_driver #(
  parameter int DATA_WIDTH      = 32,
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [7:0]            key_seed,
  input  logic [7:0]            data_seed,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  input  logic                  fifo_in_full,
  output logic                  fifo_in_wr,
  output logic [DATA_WIDTH-1:0] fifo_in_data,
  input  logic                  fifo_out_empty,
  output logic                  fifo_out_rd,
  input  logic [DATA_WIDTH-1:0] fifo_out_data,
  output logic                  result_valid,
  output logic [7:0]            result_data,
  output logic [CNT_WIDTH-1:0]  result_index,
  output logic [CNT_WIDTH-1:0]  sent_count,
  output logic [CNT_WIDTH-1:0]  recv_count,
  output logic [7:0]            checksum
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_OUT = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [7:0]           key_q, key_d;
  logic [7:0]           seed_q, seed_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic [CNT_WIDTH-1:0] recv_q, recv_d;
  logic [7:0]           chk_q, chk_d;
  logic                 res_valid_q, res_valid_d;
  logic [7:0]           res_data_q, res_data_d;
  logic [CNT_WIDTH-1:0] res_index_q, res_index_d;

  logic start_ok;
  logic active;
  logic wd_fire;
  logic unused_upper;

  // Only the low byte of a result carries information.
  assign unused_upper = ^fifo_out_data[DATA_WIDTH-1:8];

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign busy     = active;
  assign done     = (state_q == S_DONE);

  assign fifo_in_wr  = (state_q == S_RUN) && (sent_q < num_q) &&
                       ((sent_q - recv_q) < MAX_OUT) && !fifo_in_full;
  assign fifo_out_rd = active && (recv_q < sent_q) && !fifo_out_empty;

  assign result_valid = res_valid_q;
  assign result_data  = res_data_q;
  assign result_index = res_index_q;
  assign sent_count   = sent_q;
  assign recv_count   = recv_q;
  assign checksum     = chk_q;

  // Outgoing word: key byte over plaintext byte, plaintext advancing with the word ordinal.
  always_comb begin
    fifo_in_data       = '0;
    fifo_in_data[15:8] = key_q;
    fifo_in_data[7:0]  = seed_q + sent_q[7:0];
  end

`ifdef AES_DRV_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            timeout_q, timeout_d;

  // Watchdog: counts active cycles with neither push nor pop; fires on the last allowed one.
  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    wd_fire   = 1'b0;
    if (start_ok) begin
      wdog_d    = '0;
      timeout_d = 1'b0;
    end else if (active) begin
      if (fifo_in_wr || fifo_out_rd) begin
        wdog_d = '0;
      end else if (wdog_q == WD_LIM) begin
        wd_fire   = 1'b1;
        timeout_d = 1'b1;
        wdog_d    = '0;
      end else begin
        wdog_d = wdog_q + WD_ONE;
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next state, run parameters, counters, checksum and the registered result strobe.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    key_d       = key_q;
    seed_d      = seed_q;
    sent_d      = sent_q;
    recv_d      = recv_q;
    chk_d       = chk_q;
    res_valid_d = fifo_out_rd;
    res_data_d  = res_data_q;
    res_index_d = res_index_q;

    if (start_ok) begin
      num_d   = num_words;
      key_d   = key_seed;
      seed_d  = data_seed;
      sent_d  = '0;
      recv_d  = '0;
      chk_d   = '0;
      state_d = (num_words == '0) ? S_DONE : S_RUN;
    end else begin
      if (fifo_in_wr) begin
        sent_d = sent_q + CNT_ONE;
      end
      if (fifo_out_rd) begin
        recv_d      = recv_q + CNT_ONE;
        chk_d       = chk_q ^ fifo_out_data[7:0];
        res_data_d  = fifo_out_data[7:0];
        res_index_d = recv_q;
      end
      case (state_q)
        S_RUN:   if (sent_q == num_q) state_d = S_DRAIN;
        S_DRAIN: if (recv_q == num_q) state_d = S_DONE;
        default: state_d = state_q;
      endcase
      if (wd_fire) begin
        state_d = S_DONE;
      end
    end
  end

  // Main register bank; reset aborts any run back to IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      key_q       <= '0;
      seed_q      <= '0;
      sent_q      <= '0;
      recv_q      <= '0;
      chk_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      key_q       <= key_d;
      seed_q      <= seed_d;
      sent_q      <= sent_d;
      recv_q      <= recv_d;
      chk_q       <= chk_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_index_q <= res_index_d;
    end
  end

endmodule
